// File: rtl/mem_wb_stage_pkg.sv
// Shared core encodings: writeback source select and load funct3 codes.
package mem_wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load lane selection and sign/zero extension. Misalignment is reported
// unconditionally; the caller qualifies it with valid and the load select.
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the byte and halfword lanes addressed by the low address bits
    always_comb begin
        byte_v = word[7:0];
        case (offset)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = offset[1] ? word[31:16] : word[15:0];
    end

    // Extend according to load type; unknown types behave as a full word
    always_comb begin
        data     = word;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_v[7]}}, byte_v};
            F3_LBU: data = {24'd0, byte_v};
            F3_LH: begin
                data     = {{16{half_v[15]}}, half_v};
                misalign = offset[0];
            end
            F3_LHU: begin
                data     = {16'd0, half_v};
                misalign = offset[0];
            end
            default: begin
                data     = word;
                misalign = |offset;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback mux, load alignment and
// a retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_valid,
    input  logic             m_reg_write,
    input  logic [1:0]       m_wb_sel,
    input  logic [2:0]       m_funct3,
    input  logic [4:0]       m_rd,
    input  logic [31:0]      m_alu_result,
    input  logic [31:0]      m_read_data,
    input  logic [31:0]      m_pc_plus4,
    input  logic             stall,
    input  logic             flush,
    output logic             wb_reg_write,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             wb_misalign,
    output logic [CNT_W-1:0] retired
);

    logic             r_valid;
    logic             r_reg_write;
    wb_sel_e          r_wb_sel;
    logic [2:0]       r_funct3;
    logic [4:0]       r_rd;
    logic [31:0]      r_alu;
    logic [31:0]      r_rdata;
    logic [31:0]      r_pc4;
    logic [CNT_W-1:0] r_retired;

    logic [31:0]      load_data;
    logic             load_mis;

    // Pipeline register: flush kills the slot, stall holds it, else capture.
    // Payload fields are left untouched on flush since valid=0 masks them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_wb_sel    <= WB_ALU;
            r_funct3    <= 3'd0;
            r_rd        <= 5'd0;
            r_alu       <= 32'd0;
            r_rdata     <= 32'd0;
            r_pc4       <= 32'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid     <= m_valid;
            r_reg_write <= m_reg_write;
            r_wb_sel    <= wb_sel_e'(m_wb_sel);
            r_funct3    <= m_funct3;
            r_rd        <= m_rd;
            r_alu       <= m_alu_result;
            r_rdata     <= m_read_data;
            r_pc4       <= m_pc_plus4;
        end
    end

    // Count instructions actually captured into WB; wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (m_valid && !flush && !stall) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    load_align u_load_align (
        .word     (r_rdata),
        .offset   (r_alu[1:0]),
        .funct3   (r_funct3),
        .data     (load_data),
        .misalign (load_mis)
    );

    // Writeback source mux and write-enable qualification
    always_comb begin
        wb_data     = 32'd0;
        wb_misalign = r_valid && (r_wb_sel == WB_LOAD) && load_mis;
        if (r_valid) begin
            case (r_wb_sel)
                WB_LOAD: wb_data = load_data;
                WB_PC4:  wb_data = r_pc4;
                default: wb_data = r_alu;
            endcase
        end
        wb_reg_write = r_valid && r_reg_write && (r_rd != 5'd0) && !wb_misalign;
    end

    assign wb_rd   = r_rd;
    assign retired = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             m_valid, m_reg_write;
    logic [1:0]       m_wb_sel;
    logic [2:0]       m_funct3;
    logic [4:0]       m_rd;
    logic [31:0]      m_alu_result, m_read_data, m_pc_plus4;
    logic             stall, flush;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             wb_misalign;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_ret;

    always #5 clk = ~clk;

    mem_wb_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_reg_write(m_reg_write), .m_wb_sel(m_wb_sel),
        .m_funct3(m_funct3), .m_rd(m_rd), .m_alu_result(m_alu_result),
        .m_read_data(m_read_data), .m_pc_plus4(m_pc_plus4),
        .stall(stall), .flush(flush),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_misalign(wb_misalign), .retired(retired)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic        we;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4);
        m_valid = v; m_reg_write = we; m_wb_sel = sel; m_funct3 = f3;
        m_rd = rd; m_alu_result = alu; m_read_data = rdata; m_pc_plus4 = pc4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic we, input logic [4:0] rd,
                             input logic [31:0] data, input logic mis);
        check({tag, ".we"},   {31'd0, wb_reg_write}, {31'd0, we});
        check({tag, ".rd"},   {27'd0, wb_rd}, {27'd0, rd});
        check({tag, ".data"}, wb_data, data);
        check({tag, ".mis"},  {31'd0, wb_misalign}, {31'd0, mis});
        check({tag, ".ret"},  {28'd0, retired}, {28'd0, exp_ret});
    endtask

    function automatic vec_t mk(string n, logic v, logic we, logic [1:0] sel, logic [2:0] f3,
                                logic [4:0] rd, logic [31:0] alu, logic [31:0] rdata,
                                logic [31:0] pc4, logic ewe, logic [4:0] erd,
                                logic [31:0] edata, logic emis);
        vec_t t;
        t.name = n; t.valid = v; t.we = we; t.sel = sel; t.f3 = f3; t.rd = rd;
        t.alu = alu; t.rdata = rdata; t.pc4 = pc4;
        t.exp_we = ewe; t.exp_rd = erd; t.exp_data = edata; t.exp_mis = emis;
        return t;
    endfunction

    initial begin
        // name, v, we, sel, f3, rd, alu, rdata, pc4 | we, rd, data, mis
        vecs.push_back(mk("lb_0",     1,1,2'd1,3'b000,5'd5,32'h100,32'h8000_7F80,32'h0, 1,5'd5,32'hFFFF_FF80,0));
        vecs.push_back(mk("lbu_1",    1,1,2'd1,3'b100,5'd6,32'h101,32'h8000_7F80,32'h0, 1,5'd6,32'h0000_007F,0));
        vecs.push_back(mk("lbu_3",    1,1,2'd1,3'b100,5'd6,32'h103,32'h8000_7F80,32'h0, 1,5'd6,32'h0000_0080,0));
        vecs.push_back(mk("lhu_2",    1,1,2'd1,3'b101,5'd6,32'h102,32'h8000_7F80,32'h0, 1,5'd6,32'h0000_8000,0));
        vecs.push_back(mk("lh_2",     1,1,2'd1,3'b001,5'd6,32'h102,32'h8000_7F80,32'h0, 1,5'd6,32'hFFFF_8000,0));
        vecs.push_back(mk("lh_0",     1,1,2'd1,3'b001,5'd2,32'h100,32'h8000_7F80,32'h0, 1,5'd2,32'h0000_7F80,0));
        vecs.push_back(mk("lw_0",     1,1,2'd1,3'b010,5'd2,32'h100,32'h8000_7F80,32'h0, 1,5'd2,32'h8000_7F80,0));
        vecs.push_back(mk("lw_mis",   1,1,2'd1,3'b010,5'd7,32'h101,32'h8000_7F80,32'h0, 0,5'd7,32'h8000_7F80,1));
        vecs.push_back(mk("lh_mis",   1,1,2'd1,3'b001,5'd7,32'h101,32'h8000_7F80,32'h0, 0,5'd7,32'h0000_7F80,1));
        vecs.push_back(mk("lhu_mis3", 1,1,2'd1,3'b101,5'd7,32'h103,32'h8000_7F80,32'h0, 0,5'd7,32'h0000_8000,1));
        vecs.push_back(mk("lb_2b",    1,1,2'd1,3'b000,5'd8,32'h2,  32'h1234_5678,32'h0, 1,5'd8,32'h0000_0034,0));
        vecs.push_back(mk("lb_3b",    1,1,2'd1,3'b000,5'd8,32'h3,  32'h1234_5678,32'h0, 1,5'd8,32'h0000_0012,0));
        vecs.push_back(mk("alu_x0",   1,1,2'd0,3'b000,5'd0,32'h1234,32'h0,      32'h0, 0,5'd0,32'h0000_1234,0));
        vecs.push_back(mk("pc4",      1,1,2'd2,3'b000,5'd1,32'h999,32'h0,       32'h44,1,5'd1,32'h0000_0044,0));
        vecs.push_back(mk("sel3_alu", 1,1,2'd3,3'b000,5'd9,32'hDEAD_BEEF,32'h5, 32'h8, 1,5'd9,32'hDEAD_BEEF,0));
        vecs.push_back(mk("f3_011_w", 1,1,2'd1,3'b011,5'd4,32'h104,32'h8000_7F80,32'h0, 1,5'd4,32'h8000_7F80,0));
        vecs.push_back(mk("f3_110_m", 1,1,2'd1,3'b110,5'd4,32'h106,32'h8000_7F80,32'h0, 0,5'd4,32'h8000_7F80,1));
        vecs.push_back(mk("alu_mis_n",1,1,2'd0,3'b010,5'd4,32'h103,32'h0,       32'h0, 1,5'd4,32'h0000_0103,0));
        vecs.push_back(mk("nowrite",  1,0,2'd1,3'b100,5'd4,32'h100,32'h8000_7F80,32'h0, 0,5'd4,32'h0000_0080,0));
        vecs.push_back(mk("invalid",  0,1,2'd0,3'b000,5'd4,32'h55, 32'h0,       32'h0, 0,5'd4,32'h0000_0000,0));

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1, 1, 2'd0, 3'd0, 5'd3, 32'hABCD, 32'h0, 32'h0);
        tick();
        tick();
        exp_ret = '0;
        check_all("reset", 0, 5'd0, 32'd0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].sel, vecs[i].f3, vecs[i].rd,
                  vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
            tick();
            if (vecs[i].valid) exp_ret = exp_ret + 1'b1;
            check_all(vecs[i].name, vecs[i].exp_we, vecs[i].exp_rd,
                      vecs[i].exp_data, vecs[i].exp_mis);
        end

        // Stall hold: captured ALU op stays in WB while new inputs are ignored
        drive(1, 1, 2'd0, 3'd0, 5'd3, 32'h1234, 32'h0, 32'h0);
        tick();
        exp_ret = exp_ret + 1'b1;
        check_all("stall_cap", 1, 5'd3, 32'h1234, 0);
        drive(1, 1, 2'd2, 3'd0, 5'd8, 32'hFFFF, 32'h0, 32'h77);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all($sformatf("stall_hold%0d", k), 1, 5'd3, 32'h1234, 0);
        end
        flush = 1'b1;
        tick();
        check_all("flush_stall", 0, 5'd3, 32'd0, 0);
        stall = 1'b0; flush = 1'b0;

        // Flush alone kills a valid incoming instruction and does not count it
        flush = 1'b1;
        drive(1, 1, 2'd0, 3'd0, 5'd10, 32'h42, 32'h0, 32'h0);
        tick();
        check("flush_we",  {31'd0, wb_reg_write}, 32'd0);
        check("flush_ret", {28'd0, retired}, {28'd0, exp_ret});
        flush = 1'b0;

        // Wrap: from reset, 15 captures -> 0xF, 16th -> 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ret = '0;
        check("wrap_start", {28'd0, retired}, 32'd0);
        drive(1, 0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 15; k++) tick();
        check("wrap_15", {28'd0, retired}, 32'hF);
        tick();
        check("wrap_16", {28'd0, retired}, 32'h0);

        // Reset mid-stream overrides stall/flush and discards the in-flight op
        exp_ret = 4'd0;
        drive(1, 1, 2'd0, 3'd0, 5'd12, 32'hCAFE, 32'h0, 32'h0);
        tick();
        exp_ret = exp_ret + 1'b1;
        check_all("pre_rst", 1, 5'd12, 32'hCAFE, 0);
        rst = 1'b1; stall = 1'b1; flush = 1'b0;
        drive(1, 1, 2'd1, 3'b010, 5'd13, 32'h101, 32'hFFFF_FFFF, 32'h0);
        tick();
        exp_ret = '0;
        check_all("mid_rst", 0, 5'd0, 32'd0, 0);
        rst = 1'b0; stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
